// File: rtl/div_pkg.sv
// Shared encodings for the iterative divider: operation codes, FSM states and
// the iteration counter width helper.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_S = 2'b00,
        DIV_U = 2'b01,
        REM_S = 2'b10,
        REM_U = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_e;

    // Counter has to hold the value BUS_WIDTH itself, hence the extra bit.
    function automatic int cnt_width(input int bus_width);
        return $clog2(bus_width) + 1;
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == DIV_S) || (op == REM_S);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == REM_S) || (op == REM_U);
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Operand magnitude extraction before the divide and sign restoration of the
// raw quotient/remainder afterwards. Purely combinational.
module div_sign_fix #(
    parameter int W = 64
) (
    input  logic         is_signed,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] dvd_mag,
    output logic [W-1:0] dsr_mag,
    output logic         quo_neg,
    output logic         rem_neg,
    input  logic         quo_neg_q,
    input  logic         rem_neg_q,
    input  logic [W-1:0] quo_raw,
    input  logic [W-1:0] rem_raw,
    output logic [W-1:0] quo_fix,
    output logic [W-1:0] rem_fix
);

    logic dvd_neg;
    logic dsr_neg;

    assign dvd_neg = is_signed & dividend[W-1];
    assign dsr_neg = is_signed & divisor[W-1];

    assign dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
    assign dsr_mag = dsr_neg ? (~divisor + 1'b1) : divisor;

    // Remainder follows the dividend's sign; quotient is negative when signs differ.
    assign quo_neg = dvd_neg ^ dsr_neg;
    assign rem_neg = dvd_neg;

    assign quo_fix = quo_neg_q ? (~quo_raw + 1'b1) : quo_raw;
    assign rem_fix = rem_neg_q ? (~rem_raw + 1'b1) : rem_raw;

endmodule

// File: rtl/iter_div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with divide-by-zero and signed overflow resolved without iterating.
module iter_div_unit
    import div_pkg::*;
#(
    parameter int BUS_WIDTH = 64,
    parameter int OP_WIDTH  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [OP_WIDTH-1:0]  div_op,
    input  logic [BUS_WIDTH-1:0] dividend,
    input  logic [BUS_WIDTH-1:0] divisor,
    input  logic                 flush,
    output logic                 div_stall,
    output logic                 valid,
    output logic [BUS_WIDTH-1:0] result
);

    localparam int CNT_W = cnt_width(BUS_WIDTH);
    localparam logic [BUS_WIDTH-1:0] MIN_INT = {1'b1, {(BUS_WIDTH-1){1'b0}}};

    // Handshake: start is honoured only in IDLE and carries valid operands that
    // cycle; div_stall holds the issuing stage until the result cycle; valid is a
    // one-cycle pulse during which result must be captured (there is no ready).
    div_state_e state, state_nxt;

    logic [OP_WIDTH-1:0]  op_q;
    logic [BUS_WIDTH:0]   rem_q;
    logic [BUS_WIDTH-1:0] quo_q;
    logic [BUS_WIDTH-1:0] dsr_q;
    logic                 quo_neg_q;
    logic                 rem_neg_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BUS_WIDTH-1:0] result_q;

    logic                 in_signed;
    logic                 div_by_zero;
    logic                 overflow;
    logic                 special;
    logic                 accept;
    logic                 last_step;

    logic [BUS_WIDTH:0]   shifted;
    logic                 fits;
    logic [BUS_WIDTH:0]   rem_step;
    logic [BUS_WIDTH-1:0] quo_step;

    logic [BUS_WIDTH-1:0] dvd_mag;
    logic [BUS_WIDTH-1:0] dsr_mag;
    logic                 quo_neg;
    logic                 rem_neg;
    logic [BUS_WIDTH-1:0] quo_fix;
    logic [BUS_WIDTH-1:0] rem_fix;

    // The partial remainder stays below the divisor, so its top bit is always 0.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_q[BUS_WIDTH];

    assign in_signed   = op_is_signed(div_op);
    assign div_by_zero = (divisor == '0);
    assign overflow    = in_signed && (dividend == MIN_INT) && (divisor == '1);
    assign special     = div_by_zero || overflow;
    assign accept      = (state == IDLE) && start && !flush;
    assign last_step   = (state == CALC) && (cnt_q == CNT_W'(1));

    div_sign_fix #(.W(BUS_WIDTH)) u_sign_fix (
        .is_signed (in_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .dvd_mag   (dvd_mag),
        .dsr_mag   (dsr_mag),
        .quo_neg   (quo_neg),
        .rem_neg   (rem_neg),
        .quo_neg_q (quo_neg_q),
        .rem_neg_q (rem_neg_q),
        .quo_raw   (quo_step),
        .rem_raw   (rem_step[BUS_WIDTH-1:0]),
        .quo_fix   (quo_fix),
        .rem_fix   (rem_fix)
    );

    always_comb begin
        shifted  = {rem_q[BUS_WIDTH-1:0], quo_q[BUS_WIDTH-1]};
        fits     = (shifted >= {1'b0, dsr_q});
        rem_step = fits ? (shifted - {1'b0, dsr_q}) : shifted;
        quo_step = {quo_q[BUS_WIDTH-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = special ? DONE : CALC;
            CALC: if (cnt_q == CNT_W'(1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else if (accept) begin
            op_q <= div_op;
            if (div_by_zero) begin
                result_q <= op_is_rem(div_op) ? dividend : '1;
            end else if (overflow) begin
                result_q <= op_is_rem(div_op) ? '0 : MIN_INT;
            end else begin
                rem_q     <= '0;
                quo_q     <= dvd_mag;
                dsr_q     <= dsr_mag;
                quo_neg_q <= quo_neg;
                rem_neg_q <= rem_neg;
                cnt_q     <= CNT_W'(BUS_WIDTH);
            end
        end else if ((state == CALC) && !flush) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q - CNT_W'(1);
            if (last_step) begin
                result_q <= op_is_rem(op_q) ? rem_fix : quo_fix;
            end
        end
    end

    assign div_stall = ((state == IDLE) && start) || (state == CALC);
    assign valid     = (state == DONE);
    assign result    = result_q;

endmodule
